// File: rtl/ov_stream_gen.sv
// rtl/ov_stream_gen.sv - OV7670-style RGB565 pixel stream generator with test patterns
module ov_stream_gen #(
    parameter int H_ACTIVE = 320,
    parameter int H_BLANK  = 144,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 240,
    parameter int V_FRONT  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        work_en,
    input  logic [1:0]  mode,
    input  logic [15:0] const_pix,
    output logic        ov_pclk,
    output logic        ov_vs,
    output logic        ov_hs,
    output logic [7:0]  cam_data,
    output logic        frame_done,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

    state_t      state_q, state_d;
    logic [11:0] hcnt_q, hcnt_d;
    logic [11:0] lcnt_q, lcnt_d;
    logic [1:0]  mode_q, mode_d;
    logic [15:0] cpix_q, cpix_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic        pclk_q;

    logic        tick;
    logic        line_end;
    logic [11:0] state_lines;
    logic [10:0] x;
    logic [2:0]  bar;
    logic [15:0] pix;
    logic        hs_w;

    // State advances while pclk is high, so data changes on pclk falling edges
    assign tick     = pclk_q;
    assign line_end = (hcnt_q == 12'(LINE_LEN - 1));

    always_comb begin
        state_lines = 12'd1;
        case (state_q)
            S_VSYNC:  state_lines = 12'(V_SYNC);
            S_VBACK:  state_lines = 12'(V_BACK);
            S_ACTIVE: state_lines = 12'(V_ACTIVE);
            S_VFRONT: state_lines = 12'(V_FRONT);
            default:  state_lines = 12'd1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        lcnt_d  = lcnt_q;
        mode_d  = mode_q;
        cpix_d  = cpix_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        fcnt_d  = fcnt_q;
        if (tick) begin
            if (state_q == S_IDLE) begin
                hcnt_d = 12'd0;
                lcnt_d = 12'd0;
                if (work_en) begin
                    state_d = S_VSYNC;
                    mode_d  = mode;
                    cpix_d  = const_pix;
                    busy_d  = 1'b1;
                end
            end else begin
                hcnt_d = line_end ? 12'd0 : hcnt_q + 12'd1;
                if (line_end) begin
                    if (lcnt_q == state_lines - 12'd1) begin
                        lcnt_d = 12'd0;
                        case (state_q)
                            S_VSYNC:  state_d = S_VBACK;
                            S_VBACK:  state_d = S_ACTIVE;
                            S_ACTIVE: state_d = S_VFRONT;
                            default: begin
                                done_d = 1'b1;
                                fcnt_d = fcnt_q + 16'd1;
                                // Back-to-back: the next frame starts on the same tick
                                if (work_en) begin
                                    state_d = S_VSYNC;
                                    mode_d  = mode;
                                    cpix_d  = const_pix;
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = S_IDLE;
                                    busy_d  = 1'b0;
                                end
                            end
                        endcase
                    end else begin
                        lcnt_d = lcnt_q + 12'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pclk_q  <= 1'b0;
            state_q <= S_IDLE;
            hcnt_q  <= 12'd0;
            lcnt_q  <= 12'd0;
            mode_q  <= 2'd0;
            cpix_q  <= 16'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fcnt_q  <= 16'd0;
        end else begin
            pclk_q  <= ~pclk_q;
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            lcnt_q  <= lcnt_d;
            mode_q  <= mode_d;
            cpix_q  <= cpix_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign x = hcnt_q[11:1];

    // bar = floor(x*8/H_ACTIVE) via threshold compares instead of a divider
    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (int'(x) * 8 >= k * H_ACTIVE) bar = 3'(k);
        end
    end

    always_comb begin
        pix = 16'h0000;
        case (mode_q)
            2'd0: begin
                case (bar)
                    3'd0: pix = 16'hFFFF;
                    3'd1: pix = 16'hFFE0;
                    3'd2: pix = 16'h07FF;
                    3'd3: pix = 16'h07E0;
                    3'd4: pix = 16'hF81F;
                    3'd5: pix = 16'hF800;
                    3'd6: pix = 16'h001F;
                    3'd7: pix = 16'h0000;
                endcase
            end
            2'd1:    pix = {x[8:4], lcnt_q[7:2], x[4:0]};
            2'd2:    pix = cpix_q;
            default: pix = (x[4] ^ lcnt_q[4]) ? 16'hFFFF : 16'h0000;
        endcase
    end

    assign hs_w       = (state_q == S_ACTIVE) && (hcnt_q < 12'(2 * H_ACTIVE));
    assign ov_pclk    = pclk_q;
    assign ov_vs      = (state_q == S_VSYNC);
    assign ov_hs      = hs_w;
    assign cam_data   = hs_w ? (hcnt_q[0] ? pix[7:0] : pix[15:8]) : 8'h00;
    assign frame_done = done_q;
    assign busy       = busy_q;
    assign frame_cnt  = fcnt_q;

endmodule
